// File: rtl/dmx_pkg.sv
// dmx_pkg: shared DMX512 definitions (state encoding, slot framing, line rate)
// used by the framer and, later, the receive side.
package dmx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BREAK = 3'd1,
    ST_MAB   = 3'd2,
    ST_SLOTS = 3'd3,
    ST_TAIL  = 3'd4
  } dmx_state_e;

  localparam int          SLOT_BITS              = 11;
  localparam logic [7:0]  DMX_START_CODE_DEFAULT = 8'h00;
  localparam int          DMX_BAUD               = 250_000;

endpackage

// File: rtl/dmx_framer_if.sv
// dmx_framer_if: frame control, slot fetch bus and line/status signals of the
// DMX framer. master = frame controller / slot memory side, slave = framer.
interface dmx_framer_if #(
  parameter int SLOT_W = 10
);
  logic              continuous;
  logic              start;
  logic [SLOT_W-1:0] num_slots;
  logic [7:0]        start_code;
  logic              slot_req;
  logic [SLOT_W-1:0] slot_addr;
  logic [7:0]        slot_byte;
  logic              dmx_data;
  logic              busy;
  logic              frame_done;

  modport master (
    output continuous, start, num_slots, start_code, slot_byte,
    input  slot_req, slot_addr, dmx_data, busy, frame_done
  );

  modport slave (
    input  continuous, start, num_slots, start_code, slot_byte,
    output slot_req, slot_addr, dmx_data, busy, frame_done
  );
endinterface

// File: rtl/dmx_baudgen.sv
// dmx_baudgen: free-running divider producing a one-clock tick every DIV clocks.
module dmx_baudgen #(
  parameter int DIV = 48
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick on the last count of each period, then wrap to zero.
  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Divider counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dmx_framer.sv
// dmx_framer: DMX512 transmit framer. Produces BREAK, MAB, start-code slot,
// N data slots fetched one bit-time ahead, and a mark tail, all paced by the
// baud tick. Optional DEBUG port enabled by defining DMX_FRAMER_DEBUG_EN.
module dmx_framer
  import dmx_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUD       = 250_000,
  parameter int MAX_SLOTS  = 512,
  parameter int BREAK_BITS = 25,
  parameter int MAB_BITS   = 3,
  parameter int IDLE_BITS  = 2,
  localparam int SLOT_W    = $clog2(MAX_SLOTS + 1)
) (
  input  logic              CLK12,
  input  logic              RESET_N,
  input  logic              continuous,
  input  logic              start,
  input  logic [SLOT_W-1:0] num_slots,
  input  logic [7:0]        start_code,
  output logic              slot_req,
  output logic [SLOT_W-1:0] slot_addr,
  input  logic [7:0]        slot_byte,
  output logic              dmx_data,
  output logic              busy,
  output logic              frame_done
`ifdef DMX_FRAMER_DEBUG_EN
  ,
  output logic [7:0]        DEBUG
`endif
);
  localparam int DIV = CLK_HZ / BAUD;

  dmx_state_e        state_q, state_d;
  logic [7:0]        bit_cnt_q, bit_cnt_d;
  logic [SLOT_W-1:0] slot_idx_q, slot_idx_d;
  logic [SLOT_W-1:0] n_q, n_d;
  logic [SLOT_W-1:0] slot_addr_q, slot_addr_d;
  logic              slot_req_q, slot_req_d;
  logic              req_d1_q, req_d1_d;
  logic              pend_q, pend_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        cur_byte_q, cur_byte_d;
  logic [7:0]        next_byte_q, next_byte_d;
  logic              tick;

  // Saturate the requested slot count into 1..MAX_SLOTS.
  function automatic logic [SLOT_W-1:0] clamp_slots(input logic [SLOT_W-1:0] n);
    if (n == '0)                      return SLOT_W'(1);
    else if (n > SLOT_W'(MAX_SLOTS))  return SLOT_W'(MAX_SLOTS);
    else                              return n;
  endfunction

  dmx_baudgen #(.DIV(DIV)) u_baud (
    .clk   (CLK12),
    .rst_n (RESET_N),
    .tick  (tick)
  );

  assign busy       = (state_q != ST_IDLE);
  assign slot_req   = slot_req_q;
  assign slot_addr  = slot_addr_q;
  assign frame_done = frame_done_q;

`ifdef DMX_FRAMER_DEBUG_EN
  assign DEBUG = {bit_cnt_q[4:0], state_q};
`endif

  // Next-state logic: phase sequencing on ticks, slot prefetch, start latch.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    slot_idx_d   = slot_idx_q;
    n_d          = n_q;
    slot_addr_d  = slot_addr_q;
    slot_req_d   = 1'b0;
    frame_done_d = 1'b0;
    cur_byte_d   = cur_byte_q;
    // fetched byte arrives the clock after the strobe; used directly if
    // that clock is also the slot boundary
    req_d1_d     = slot_req_q;
    next_byte_d  = req_d1_q ? slot_byte : next_byte_q;
    pend_d       = pend_q | (start & ~busy);
    if (tick) begin
      bit_cnt_d = bit_cnt_q + 8'd1;
      case (state_q)
        ST_IDLE: begin
          bit_cnt_d = '0;
          if (continuous || pend_q) begin
            state_d    = ST_BREAK;
            pend_d     = 1'b0;
            n_d        = clamp_slots(num_slots);
            cur_byte_d = start_code;
          end
        end
        ST_BREAK: if (bit_cnt_q == 8'(BREAK_BITS - 1)) begin
          state_d   = ST_MAB;
          bit_cnt_d = '0;
        end
        ST_MAB: if (bit_cnt_q == 8'(MAB_BITS - 1)) begin
          state_d    = ST_SLOTS;
          bit_cnt_d  = '0;
          slot_idx_d = '0;
        end
        ST_SLOTS: begin
          if (bit_cnt_q == 8'(SLOT_BITS - 2) && slot_idx_q != n_q) begin
            slot_req_d  = 1'b1;
            slot_addr_d = slot_idx_q + 1'b1;
          end
          if (bit_cnt_q == 8'(SLOT_BITS - 1)) begin
            bit_cnt_d = '0;
            if (slot_idx_q == n_q) begin
              state_d = ST_TAIL;
            end else begin
              slot_idx_d = slot_idx_q + 1'b1;
              cur_byte_d = next_byte_d;
            end
          end
        end
        ST_TAIL: if (bit_cnt_q == 8'(IDLE_BITS - 1)) begin
          state_d      = ST_IDLE;
          bit_cnt_d    = '0;
          frame_done_d = 1'b1;
        end
        default: begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  // Line encoding: space during BREAK and start bits, data LSB first, mark otherwise.
  always_comb begin
    dmx_data = 1'b1;
    case (state_q)
      ST_BREAK: dmx_data = 1'b0;
      ST_SLOTS: begin
        if (bit_cnt_q == 8'd0)       dmx_data = 1'b0;
        else if (bit_cnt_q <= 8'd8)  dmx_data = cur_byte_q[bit_cnt_q[2:0] - 3'd1];
        else                         dmx_data = 1'b1;
      end
      default: dmx_data = 1'b1;
    endcase
  end

  // Control registers; reset aborts any frame and drops a pending start.
  always_ff @(posedge CLK12 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      slot_idx_q   <= '0;
      n_q          <= SLOT_W'(1);
      slot_addr_q  <= '0;
      slot_req_q   <= 1'b0;
      req_d1_q     <= 1'b0;
      pend_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      slot_idx_q   <= slot_idx_d;
      n_q          <= n_d;
      slot_addr_q  <= slot_addr_d;
      slot_req_q   <= slot_req_d;
      req_d1_q     <= req_d1_d;
      pend_q       <= pend_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Slot data registers; always loaded before they reach the line.
  always_ff @(posedge CLK12) begin
    cur_byte_q  <= cur_byte_d;
    next_byte_q <= next_byte_d;
  end
endmodule

// File: tb/tb_dmx_framer.sv
// tb_dmx_framer: table-driven, randomized and hand-sequenced checks of the
// DMX framer against a bit-level frame model built from the line format rules.
`timescale 1ns/1ps
module tb_dmx_framer;
  localparam int CLK_HZ     = 1_000_000;
  localparam int BAUD       = 250_000;
  localparam int DIV        = CLK_HZ / BAUD;
  localparam int MAX_SLOTS  = 512;
  localparam int BREAK_BITS = 25;
  localparam int MAB_BITS   = 3;
  localparam int IDLE_BITS  = 2;
  localparam int SW         = $clog2(MAX_SLOTS + 1);
  localparam int HDR        = BREAK_BITS + MAB_BITS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmx_framer_if #(.SLOT_W(SW)) bus ();

`ifdef DMX_FRAMER_DEBUG_EN
  logic [7:0] dbg;
`endif

  dmx_framer #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .MAX_SLOTS(MAX_SLOTS),
    .BREAK_BITS(BREAK_BITS), .MAB_BITS(MAB_BITS), .IDLE_BITS(IDLE_BITS)
  ) dut (
    .CLK12      (clk),
    .RESET_N    (rst_n),
    .continuous (bus.continuous),
    .start      (bus.start),
    .num_slots  (bus.num_slots),
    .start_code (bus.start_code),
    .slot_req   (bus.slot_req),
    .slot_addr  (bus.slot_addr),
    .slot_byte  (bus.slot_byte),
    .dmx_data   (bus.dmx_data),
    .busy       (bus.busy),
    .frame_done (bus.frame_done)
`ifdef DMX_FRAMER_DEBUG_EN
    ,
    .DEBUG      (dbg)
`endif
  );

  logic [7:0] mem [0:1023];
  logic       obs [0:63];
  int tests = 0;
  int fails = 0;
  int last_wait = 0;

  // Slot memory: answers a strobe one clock later, garbage at all other times.
  always @(posedge clk) bus.slot_byte <= bus.slot_req ? mem[bus.slot_addr] : 8'($urandom);

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic expect_quiet(input int cyc, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.dmx_data !== 1'b1 || bus.frame_done !== 1'b0) bad++;
    end
    chk(name, 32'(bad), 0);
  endtask

  // Waits for a frame to begin, then checks every clock of it against the
  // expected bit stream; returns on the clock frame_done should be high.
  task automatic check_frame(input int n, input logic [7:0] sc, input string tag);
    logic       q[$];
    logic [7:0] bv;
    logic       exp_req;
    int w, total, b, k, bad_line, bad_req, bad_busy, nreq;
    q = {};
    for (int i = 0; i < BREAK_BITS; i++) q.push_back(1'b0);
    for (int i = 0; i < MAB_BITS; i++)   q.push_back(1'b1);
    for (int s = 0; s <= n; s++) begin
      bv = (s == 0) ? sc : mem[s];
      q.push_back(1'b0);
      for (int j = 0; j < 8; j++) q.push_back(bv[j]);
      q.push_back(1'b1);
      q.push_back(1'b1);
    end
    for (int i = 0; i < IDLE_BITS; i++) q.push_back(1'b1);
    total = q.size();
    w = 0;
    while (bus.busy !== 1'b1 && w < 200 * DIV) begin
      @(negedge clk);
      w++;
    end
    last_wait = w;
    chk({tag, "_start"}, 32'(bus.busy), 1);
    if (bus.busy !== 1'b1) return;
    bad_line = 0; bad_req = 0; bad_busy = 0; nreq = 0;
    for (int c = 0; c < total * DIV; c++) begin
      b = c / DIV;
      k = (b - HDR) / 11;
      exp_req = (c % DIV == 0) && (b >= HDR) && ((b - HDR) % 11 == 10) && (k < n);
      if (bus.dmx_data !== q[b]) bad_line++;
      if (bus.slot_req !== exp_req) bad_req++;
      if (exp_req && bus.slot_addr !== SW'(k + 1)) bad_req++;
      if (bus.slot_req === 1'b1) nreq++;
      if (bus.busy !== 1'b1 || bus.frame_done !== 1'b0) bad_busy++;
      if (c % DIV == DIV / 2 && b < 64) obs[b] = bus.dmx_data;
      @(negedge clk);
    end
    chk({tag, "_line"},      32'(bad_line), 0);
    chk({tag, "_slot_req"},  32'(bad_req), 0);
    chk({tag, "_busy"},      32'(bad_busy), 0);
    chk({tag, "_nreq"},      32'(nreq), 32'(n));
    chk({tag, "_done"},      32'(bus.frame_done), 1);
    chk({tag, "_busy_end"},  32'(bus.busy), 0);
    chk({tag, "_mark_end"},  32'(bus.dmx_data), 1);
    chk({tag, "_addr_end"},  32'(bus.slot_addr), 32'(n));
  endtask

  typedef struct {
    logic [SW-1:0] ns;
    logic [7:0]    sc;
    logic [7:0]    b1;
    int            exp_n;
  } vec_t;

  vec_t       vec [4];
  logic [21:0] obs22;
  int         bad, ns_r, en_r;
  logic [7:0] sc_r;

  initial begin
    vec[0] = '{ns: SW'(1),   sc: 8'hCC, b1: 8'hA5, exp_n: 1};
    vec[1] = '{ns: SW'(0),   sc: 8'h3C, b1: 8'h5A, exp_n: 1};
    vec[2] = '{ns: SW'(600), sc: 8'h00, b1: 8'hFF, exp_n: 512};
    vec[3] = '{ns: SW'(3),   sc: 8'h81, b1: 8'h01, exp_n: 3};

    rst_n = 1'b0;
    bus.continuous = 1'b0;
    bus.start      = 1'b0;
    bus.num_slots  = '0;
    bus.start_code = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_dmx",   32'(bus.dmx_data), 1);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_req",   32'(bus.slot_req), 0);
    chk("rst_done",  32'(bus.frame_done), 0);
    chk("rst_addr",  32'(bus.slot_addr), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single-frame table
    for (int t = 0; t < 4; t++) begin
      for (int k = 1; k <= MAX_SLOTS; k++) mem[k] = 8'($urandom);
      mem[1] = vec[t].b1;
      bus.num_slots  = vec[t].ns;
      bus.start_code = vec[t].sc;
      pulse_start();
      check_frame(vec[t].exp_n, vec[t].sc, $sformatf("vec%0d", t));
      if (t == 0) begin
        for (int i = 0; i < 22; i++) obs22[21 - i] = obs[HDR + i];
        chk("cc_a5_bits", 32'(obs22), 32'(22'b00011001111_01010010111));
      end
      expect_quiet(4 * DIV, $sformatf("vec%0d_quiet", t));
    end

    // Randomized single frames
    for (int r = 0; r < 5; r++) begin
      ns_r = $urandom_range(0, 24);
      en_r = (ns_r == 0) ? 1 : ((ns_r > MAX_SLOTS) ? MAX_SLOTS : ns_r);
      sc_r = 8'($urandom);
      for (int k = 1; k <= 24; k++) mem[k] = 8'($urandom);
      bus.num_slots  = SW'(ns_r);
      bus.start_code = sc_r;
      pulse_start();
      check_frame(en_r, sc_r, $sformatf("rnd%0d", r));
      expect_quiet(4 * DIV, $sformatf("rnd%0d_quiet", r));
    end

    // Continuous frames, slot count change mid-frame, then stop mid-frame
    for (int k = 1; k <= 8; k++) mem[k] = 8'(k * 8'h11);
    bus.num_slots  = SW'(4);
    bus.start_code = 8'h00;
    bus.continuous = 1'b1;
    check_frame(4, 8'h00, "cont_a");
    fork
      check_frame(4, 8'h00, "cont_b");
      begin
        repeat (60 * DIV) @(negedge clk);
        bus.num_slots = SW'(7);
      end
    join
    chk("cont_gap", 32'(last_wait), 32'(DIV));
    fork
      check_frame(7, 8'h00, "cont_c");
      begin
        repeat (60 * DIV) @(negedge clk);
        bus.continuous = 1'b0;
      end
    join
    expect_quiet(6 * DIV, "cont_stop");

    // Start while busy is ignored
    bus.num_slots  = SW'(2);
    bus.start_code = 8'h5A;
    pulse_start();
    fork
      check_frame(2, 8'h5A, "busy_start");
      begin
        repeat (40 * DIV) @(negedge clk);
        pulse_start();
      end
    join
    expect_quiet(6 * DIV, "busy_start_ignored");

    // Reset clears a pending start
    pulse_start();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet(8 * DIV, "rst_clears_pend");

    // Reset in the start bit of slot 3 aborts the frame
    bus.num_slots  = SW'(5);
    bus.start_code = 8'h77;
    pulse_start();
    bad = 0;
    while (bus.busy !== 1'b1 && bad < 100 * DIV) begin
      @(negedge clk);
      bad++;
    end
    chk("abort_started", 32'(bus.busy), 1);
    repeat (DIV * (HDR + 33)) @(negedge clk);
    chk("abort_pre_space", 32'(bus.dmx_data), 0);
    rst_n = 1'b0;
    #1;
    chk("abort_dmx",  32'(bus.dmx_data), 1);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_req",  32'(bus.slot_req), 0);
    chk("abort_addr", 32'(bus.slot_addr), 0);
    chk("abort_done", 32'(bus.frame_done), 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0 || bus.dmx_data !== 1'b1) bad++;
    end
    chk("abort_hold", 32'(bad), 0);
    rst_n = 1'b1;
    expect_quiet(4 * DIV, "abort_after");
    pulse_start();
    check_frame(5, 8'h77, "abort_fresh");
    expect_quiet(4 * DIV, "abort_fresh_quiet");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmx_framer.md
DMX_FRAMER -- requirements
Module: dmx_framer

Interface
REQ-001 SHALL have parameter CLK_HZ, 12_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, 250_000, line bit rate; DIV = CLK_HZ/BAUD clocks per bit.
REQ-003 SHALL have parameter MAX_SLOTS, 512, largest data-slot count supported; SLOT_W = clog2(MAX_SLOTS+1).
REQ-004 SHALL have parameter BREAK_BITS, 25, break length in bit times.
REQ-005 SHALL have parameter MAB_BITS, 3, mark-after-break length in bit times.
REQ-006 SHALL have parameter IDLE_BITS, 2, mark time after the last slot, in bit times.
REQ-007 SHALL have port CLK12  in  1  system clock, the only clock.
REQ-008 SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have port continuous  in  1  1 = back-to-back frames; 0 = one frame per start.
REQ-010 SHALL have port start  in  1  one-clock request for a single frame.
REQ-011 SHALL have port num_slots  in  SLOT_W  data slots per frame, excluding the start code.
REQ-012 SHALL have port start_code  in  8  slot-0 value.
REQ-013 SHALL have port slot_req  out  1  one-clock fetch strobe.
REQ-014 SHALL have port slot_addr  out  SLOT_W  index of the slot being fetched (1..N).
REQ-015 SHALL have port slot_byte  in  8  fetched data, valid on the clock after slot_req.
REQ-016 SHALL have port dmx_data  out  1  serial line, 1 = mark.
REQ-017 SHALL have port busy  out  1  high from BREAK entry through the end of IDLE_TAIL.
REQ-018 SHALL have port frame_done  out  1  one-clock pulse when a frame completes.

Function
REQ-019 SHALL implement states IDLE, BREAK, MAB, SLOTS and IDLE_TAIL, advancing only on the baud tick, which occurs once every DIV clocks.
REQ-020 IDLE SHALL drive mark and SHALL enter BREAK on the next tick when continuous=1 or a latched start is pending.
REQ-021 A start pulse arriving while busy=1 SHALL be ignored and SHALL not be latched.
REQ-022 On BREAK entry, num_slots and start_code SHALL be latched for the whole frame.
REQ-023 num_slots=0 SHALL be clamped to 1, and num_slots>MAX_SLOTS SHALL be clamped to MAX_SLOTS.
REQ-024 BREAK SHALL drive space for exactly BREAK_BITS bit times.
REQ-025 MAB SHALL drive mark for exactly MAB_BITS bit times.
REQ-026 Each slot SHALL be 11 bits: start bit 0, then 8 data bits LSB first, then two stop bits of 1.
REQ-027 Slot 0 SHALL carry the latched start_code, followed by slots 1..N with no inter-slot gap.
REQ-028 The slot_req pulse for slot k SHALL occur on the first clock of the last bit of slot k-1 (for slot 1, the last bit of slot 0), with slot_addr=k.
REQ-029 slot_byte SHALL be captured on the clock after slot_req; its value at any other time SHALL be ignored.
REQ-030 After slot N, the block SHALL enter IDLE_TAIL and drive mark for IDLE_BITS bit times.
REQ-031 frame_done SHALL pulse on the clock IDLE_TAIL exits, after which the block SHALL return to IDLE.
REQ-032 Deasserting continuous mid-frame SHALL let the current frame complete, after which no new frame SHALL start.
REQ-033 slot_addr SHALL hold its last value between strobes.
REQ-034 The slot counter SHALL never wrap.

Reset
REQ-035 While RESET_N=0, outputs SHALL be: dmx_data=1, busy=0, slot_req=0, frame_done=0, slot_addr=0.
REQ-036 While RESET_N=0, state SHALL be IDLE, the baud counter SHALL be 0, and a pending start SHALL be cleared.
REQ-037 Reset asserted mid-frame SHALL abort the frame immediately, with line at mark and no frame_done pulse.

Configuration
REQ-038 With DMX_FRAMER_DEBUG_EN defined, the block SHALL add output DEBUG[7:0] = {bit_cnt[4:0], state[2:0]}.
REQ-039 Without DMX_FRAMER_DEBUG_EN, the DEBUG port and its logic SHALL be absent, with no other behavioural change.

Structure
REQ-040 Shared package dmx_pkg SHALL hold the state enumeration, SLOT_BITS=11, DMX_START_CODE_DEFAULT=8'h00 and DMX_BAUD=250_000.
REQ-041 The baud tick SHALL be a sub-module dmx_baudgen (parameter DIV; outputs tick), reused by the receive side later.

Verification
REQ-042 continuous=1, num_slots=4, start_code=0x00, slot_byte=addr*0x11 -> break of 25*48 clocks, MAB of 3*48 clocks, bytes 00,11,22,33,44, 2-bit tail, frame_done pulse, then the next break.
REQ-043 continuous=0, single start pulse -> exactly one frame and one frame_done, line stays at mark afterwards, busy=0.
REQ-044 num_slots=0 -> 1 data slot is sent; num_slots=600 with MAX_SLOTS=512 -> 512 data slots are sent, with slot_addr ending at 512.
REQ-045 start_code=0xCC, one slot_byte=0xA5 -> line bits 0,0,0,1,1,0,0,1,1,1,1, then 0,1,0,1,0,0,1,0,1,1,1.
REQ-046 RESET_N pulsed low during slot 3 -> dmx_data=1 within the same clock, busy=0, no frame_done; a fresh break follows a start.
REQ-047 start pulsed while busy=1 -> no extra frame.
REQ-048 num_slots changed mid-frame -> the current frame's slot count is unchanged.
